// File: rtl/multicycle_ctrl_if.sv
// Instruction/data memory handshake bundle for the multi-cycle sequencing controller.
// The controller side uses the master modport; memories and the ALU drive the slave side.
interface multicycle_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic [31:0] alu_result;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we,
    input  imem_ready, imem_rdata, dmem_ready, alu_result
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we,
    output imem_ready, imem_rdata, dmem_ready, alu_result
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB with stallable memories,
// a program counter, a retire counter and a sticky illegal-opcode halt.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.master   mem,
  output logic [31:0]         pc,
  output logic [31:0]         instr,
  output logic [3:0]          ALU_control,
  output logic                Imm_mux_SEL,
  output logic                RegWE,
  output logic                wb_sel,
  output logic                illegal,
  output logic [31:0]         instret
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instret_q, instret_d;
  logic        illegal_q, illegal_d;

  logic        imem_req, dmem_req, dmem_we;
  logic [3:0]  alu_ctrl;
  logic        reg_we, wb_sel_c;

  // Class is re-derived from the held instruction register rather than stored.
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        is_r, is_ialu, is_load, is_store, is_legal, is_mem;
  logic [3:0]  alu_op;

  assign opcode   = instr_q[6:0];
  assign funct3   = instr_q[14:12];
  assign is_r     = (opcode == 7'b0110011);
  assign is_ialu  = (opcode == 7'b0010011);
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  assign is_legal = is_r | is_ialu | is_load | is_store;
  assign is_mem   = is_load | is_store;

  always_comb begin
    alu_op = 4'b0000;
    if (is_r || is_ialu) begin
      unique case (funct3)
        3'b000: alu_op = (is_r && instr_q[30]) ? 4'b0001 : 4'b0000;
        3'b001: alu_op = 4'b0010;
        3'b010: alu_op = 4'b0011;
        3'b011: alu_op = 4'b0100;
        3'b100: alu_op = 4'b0101;
        3'b101: alu_op = instr_q[30] ? 4'b0111 : 4'b0110;
        3'b110: alu_op = 4'b1000;
        3'b111: alu_op = 4'b1001;
        default: alu_op = 4'b0000;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    illegal_d = illegal_q;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_ctrl  = 4'b0000;
    reg_we    = 1'b0;
    wb_sel_c  = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (mem.imem_ready) begin
          instr_d = mem.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_legal) begin
          state_d = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end
      end
      S_EXEC: begin
        alu_ctrl = alu_op;
        state_d  = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        if (mem.dmem_ready) begin
          if (is_store) begin
            pc_d      = pc_q + 32'd4;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        reg_we    = (instr_q[11:7] != 5'd0);
        wb_sel_c  = is_load;
        pc_d      = pc_q + 32'd4;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
      illegal_q <= illegal_d;
    end
  end

  assign mem.imem_req  = imem_req;
  assign mem.imem_addr = pc_q;
  assign mem.dmem_req  = dmem_req;
  assign mem.dmem_we   = dmem_we;

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instret     = instret_q;
  assign illegal     = illegal_q;
  assign ALU_control = alu_ctrl;
  assign Imm_mux_SEL = is_ialu | is_load | is_store;
  assign RegWE       = reg_we;
  assign wb_sel      = wb_sel_c;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: two instances (RESET_PC 0 and FFFF_FFFC) share stimulus and
// are checked every cycle against a per-instruction phase schedule built from latency rules.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        dmem_ready = 1'b0;

  always #5 clk = ~clk;

  multicycle_ctrl_if if0 ();
  multicycle_ctrl_if if1 ();
  assign if0.imem_ready = imem_ready;
  assign if0.imem_rdata = imem_rdata;
  assign if0.dmem_ready = dmem_ready;
  assign if0.alu_result = '0;
  assign if1.imem_ready = imem_ready;
  assign if1.imem_rdata = imem_rdata;
  assign if1.dmem_ready = dmem_ready;
  assign if1.alu_result = '0;

  logic [31:0] pc0, pc1, instr0, instr1, instret0, instret1;
  logic [3:0]  alu0, alu1;
  logic        imm0, imm1, rwe0, rwe1, wsel0, wsel1, ill0, ill1;

  multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut0 (
    .clk(clk), .rst(rst), .mem(if0.master), .pc(pc0), .instr(instr0),
    .ALU_control(alu0), .Imm_mux_SEL(imm0), .RegWE(rwe0), .wb_sel(wsel0),
    .illegal(ill0), .instret(instret0)
  );

  multicycle_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk(clk), .rst(rst), .mem(if1.master), .pc(pc1), .instr(instr1),
    .ALU_control(alu1), .Imm_mux_SEL(imm1), .RegWE(rwe1), .wb_sel(wsel1),
    .illegal(ill1), .instret(instret1)
  );

  int vectors = 0;
  int miscompares = 0;

  // Architectural model: what a retired-instruction view says the registers must hold.
  logic [31:0] m_pc, m_instr, m_instret;
  logic        m_illegal;

  logic [3:0]  last_alu;
  logic        last_imm;
  int          last_dreq_cnt, last_rwe_cnt;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011,
                         OP_L = 7'b0000011, OP_S = 7'b0100011;

  function automatic bit legal_op(input logic [6:0] op);
    return op == OP_R || op == OP_I || op == OP_L || op == OP_S;
  endfunction

  function automatic bit uses_imm(input logic [31:0] ins);
    return ins[6:0] == OP_I || ins[6:0] == OP_L || ins[6:0] == OP_S;
  endfunction

  // ALU code from the mnemonic table: add,sll,slt,sltu,xor,srl,or,and by funct3.
  function automatic logic [3:0] exp_alu(input logic [31:0] ins);
    logic [3:0] tab [8];
    logic [3:0] code;
    tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    if (ins[6:0] == OP_L || ins[6:0] == OP_S) return 4'd0;
    code = tab[ins[14:12]];
    if (ins[14:12] == 3'b101 && ins[30]) code = 4'd7;
    if (ins[14:12] == 3'b000 && ins[30] && ins[6:0] == OP_R) code = 4'd1;
    return code;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic check_outs(input logic ireq, input logic dreq, input logic dwe,
                            input logic [3:0] alu, input logic rwe, input logic wsel);
    logic [31:0] epc;
    for (int d = 0; d < 2; d++) begin
      epc = (d == 0) ? m_pc : m_pc + 32'hFFFF_FFFC;
      chk($sformatf("d%0d.imem_req", d), d ? if1.imem_req : if0.imem_req, ireq);
      chk($sformatf("d%0d.dmem_req", d), d ? if1.dmem_req : if0.dmem_req, dreq);
      if (dreq) chk($sformatf("d%0d.dmem_we", d), d ? if1.dmem_we : if0.dmem_we, dwe);
      chk($sformatf("d%0d.imem_addr", d), d ? if1.imem_addr : if0.imem_addr, epc);
      chk($sformatf("d%0d.pc", d), d ? pc1 : pc0, epc);
      chk($sformatf("d%0d.instr", d), d ? instr1 : instr0, m_instr);
      chk($sformatf("d%0d.instret", d), d ? instret1 : instret0, m_instret);
      chk($sformatf("d%0d.illegal", d), d ? ill1 : ill0, m_illegal);
      chk($sformatf("d%0d.ALU_control", d), d ? alu1 : alu0, alu);
      chk($sformatf("d%0d.Imm_mux_SEL", d), d ? imm1 : imm0, uses_imm(m_instr));
      chk($sformatf("d%0d.RegWE", d), d ? rwe1 : rwe0, rwe);
      chk($sformatf("d%0d.wb_sel", d), d ? wsel1 : wsel0, wsel);
    end
  endtask

  task automatic drive(input logic ir, input logic [31:0] rd, input logic dr);
    imem_ready = ir;
    imem_rdata = rd;
    dmem_ready = dr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = '0; m_instr = '0; m_instret = '0; m_illegal = 1'b0;
  endtask

  task automatic retire();
    m_pc = m_pc + 32'd4;
    m_instret = m_instret + 32'd1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    tick();
    rst = 1'b0;
    model_reset();
  endtask

  // One instruction from FETCH entry to the next FETCH; abort_at >= 0 asserts rst
  // in that MEM cycle instead of completing the access.
  task automatic run_instr(input logic [31:0] ins, input int ist, input int dst,
                           input int abort_at);
    bit ld, st;
    ld = (ins[6:0] == OP_L);
    st = (ins[6:0] == OP_S);
    last_dreq_cnt = 0;
    last_rwe_cnt = 0;
    for (int k = 0; k <= ist; k++) begin
      drive(k == ist, (k == ist) ? ins : $urandom, $urandom_range(0, 1));
      check_outs(1, 0, 0, 4'd0, 0, 0);
      tick();
    end
    m_instr = ins;
    drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    check_outs(0, 0, 0, 4'd0, 0, 0);
    tick();
    if (!legal_op(ins[6:0])) begin
      m_illegal = 1'b1;
      for (int k = 0; k < 4; k++) begin
        drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1));
        check_outs(0, 0, 0, 4'd0, 0, 0);
        tick();
      end
      return;
    end
    drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    check_outs(0, 0, 0, exp_alu(ins), 0, 0);
    last_alu = alu0;
    last_imm = imm0;
    tick();
    if (ld || st) begin
      for (int k = 0; k <= dst; k++) begin
        if (k == abort_at) begin
          rst = 1'b1;
          drive($urandom_range(0, 1), $urandom, 1'b0);
          check_outs(0, 1, st, 4'd0, 0, 0);
          tick();
          rst = 1'b0;
          model_reset();
          return;
        end
        drive($urandom_range(0, 1), $urandom, k == dst);
        check_outs(0, 1, st, 4'd0, 0, 0);
        if (if0.dmem_req) last_dreq_cnt++;
        tick();
      end
      if (st) begin
        retire();
        return;
      end
    end
    drive($urandom_range(0, 1), $urandom, $urandom_range(0, 1));
    check_outs(0, 0, 0, 4'd0, ins[11:7] != 5'd0, ld);
    if (rwe0) last_rwe_cnt++;
    tick();
    retire();
  endtask

  initial begin
    logic [31:0] ins;
    int t, ist, dst, ab;
    model_reset();
    tick();
    do_reset();

    run_instr(32'h003100B3, 0, 0, -1);
    chk("lit.add_pc", pc0, 32'h4);
    chk("lit.add_instret", instret0, 32'd1);
    chk("lit.add_pc_wrap", pc1, 32'h0);
    chk("lit.add_rwe", last_rwe_cnt, 1);

    run_instr(32'h40315093, 0, 0, -1);
    chk("lit.srai_alu", last_alu, 4'b0111);
    chk("lit.srai_imm", last_imm, 1'b1);
    run_instr(32'h40010093, 1, 0, -1);
    chk("lit.addi_alu", last_alu, 4'b0000);
    chk("lit.addi_imm", last_imm, 1'b1);

    run_instr(32'h00012083, 0, 3, -1);
    chk("lit.load_dreq_cycles", last_dreq_cnt, 4);
    chk("lit.load_rwe", last_rwe_cnt, 1);

    do_reset();
    run_instr(32'h00112023, 0, 0, -1);
    chk("lit.store_rwe", last_rwe_cnt, 0);
    run_instr(32'h00000033, 0, 0, -1);
    chk("lit.addx0_rwe", last_rwe_cnt, 0);
    chk("lit.addx0_instret", instret0, 32'd2);

    run_instr(32'h0000007F, 0, 0, -1);
    chk("lit.illegal_set", ill0, 1'b1);
    chk("lit.halt_imem_req", if0.imem_req, 1'b0);
    do_reset();
    chk("lit.illegal_clr", ill0, 1'b0);
    chk("lit.restart_addr", if0.imem_addr, 32'h0);
    chk("lit.restart_addr_hi", if1.imem_addr, 32'hFFFF_FFFC);

    run_instr(32'h00012083, 0, 3, 1);
    chk("lit.abort_dreq", if1.dmem_req, 1'b0);
    chk("lit.abort_ireq", if1.imem_req, 1'b1);

    for (int n = 0; n < 250; n++) begin
      ins = $urandom;
      t = $urandom_range(0, 9);
      case (t)
        0, 1, 2: ins[6:0] = OP_R;
        3, 4, 5: ins[6:0] = OP_I;
        6, 7:    ins[6:0] = OP_L;
        8:       ins[6:0] = OP_S;
        default: while (legal_op(ins[6:0])) ins[6:0] = 7'($urandom);
      endcase
      if ($urandom_range(0, 7) == 0) ins[11:7] = 5'd0;
      ist = $urandom_range(0, 3);
      dst = $urandom_range(0, 3);
      ab = ($urandom_range(0, 14) == 0) ? $urandom_range(0, dst) : -1;
      run_instr(ins, ist, dst, ab);
      if (!legal_op(ins[6:0])) do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
